decoder1035_arbiter: RTL and testbench

- Shares one 1035 pattern decoder (16-bit word == 16'h040B) among NREQ requesters.
- Round-robin arbitration; each granted word is decoded once.
- Result is registered into a single output slot with valid/ready handshake.
- Sits between producer ports and any consumer of match results; the only datapath is the shared decoder instance.

---
 rtl/decoder_pkg.sv | 12 +
 rtl/decoder1035_arbiter_pattern_decoder.sv | 9 +
 rtl/decoder1035_arbiter.sv | 129 ++++++++++++
 tb/tb_decoder1035_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and constants for the 1035 pattern decoder and its arbiter.
package decoder_pkg;
    localparam int DEC_W = 16;
    localparam logic [DEC_W-1:0] DEC_PATTERN = 16'd1035;

    typedef logic [DEC_W-1:0] dec_word_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;
endpackage

// File: rtl/decoder1035_arbiter_pattern_decoder.sv
// Combinational matcher: flags a word equal to the 1035 pattern (16'h040B).
module pattern_decoder
    import decoder_pkg::*;
(
    input  dec_word_t inp,
    output logic      o
);
    assign o = (inp == DEC_PATTERN);
endmodule

// File: rtl/decoder1035_arbiter.sv
// Round-robin arbiter sharing one 1035 pattern decoder across NREQ requesters.
// Optional match counter enabled by defining DEC_MATCH_COUNT_EN.
//
// state      | meaning
// SLOT_EMPTY | no result held, rsp_valid=0
// SLOT_FULL  | result held in rsp_*, waiting for rsp_ready
module decoder1035_arbiter
    import decoder_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int CNT_W = 8,
    localparam int IDW   = $clog2(NREQ)
)
(
    input  logic                  clk,
    input  logic                  rst,
`ifdef DEC_MATCH_COUNT_EN
    input  logic                  match_clr,
    output logic [CNT_W-1:0]      match_cnt,
`endif
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DEC_W-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [DEC_W-1:0]      rsp_data,
    output logic                  rsp_match
);
    if (NREQ < 2 || NREQ > 8 || CNT_W < 1) begin : g_bad_param
        $error("decoder1035_arbiter: NREQ must be 2..8 and CNT_W >= 1");
    end

    slot_state_t    r_slot;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_rsp_id;
    dec_word_t      r_rsp_data;
    logic           r_rsp_match;

    logic           w_found_hi;
    logic           w_any;
    logic [IDW-1:0] w_hi_idx;
    logic [IDW-1:0] w_lo_idx;
    logic [IDW-1:0] w_gnt_idx;
    logic [NREQ-1:0] w_grant;
    dec_word_t      w_gnt_word;
    logic           w_match;
    logic           w_can_accept;
    logic           w_accept;

    // Lowest valid index at or above the pointer wins; otherwise wrap to the lowest valid index.
    always_comb begin
        w_found_hi = 1'b0;
        w_any      = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_any    = 1'b1;
                w_lo_idx = IDW'(i);
                if (IDW'(i) >= r_rr_ptr) begin
                    w_found_hi = 1'b1;
                    w_hi_idx   = IDW'(i);
                end
            end
        end
        w_gnt_idx = w_found_hi ? w_hi_idx : w_lo_idx;
    end

    always_comb begin
        w_grant    = '0;
        w_gnt_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_any && (w_gnt_idx == IDW'(i))) begin
                w_grant[i] = 1'b1;
                w_gnt_word = req_data[i*DEC_W +: DEC_W];
            end
        end
    end

    pattern_decoder u_dec (
        .inp (w_gnt_word),
        .o   (w_match)
    );

    assign w_can_accept = !rst && ((r_slot == SLOT_EMPTY) || rsp_ready);
    assign w_accept     = w_any && w_can_accept;
    assign req_ready    = w_grant & {NREQ{w_can_accept}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot      <= SLOT_EMPTY;
            r_rr_ptr    <= '0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_match <= 1'b0;
        end else if (w_accept) begin
            // A same-cycle rsp_ready retires the old result as this one loads.
            r_slot      <= SLOT_FULL;
            r_rsp_id    <= w_gnt_idx;
            r_rsp_data  <= w_gnt_word;
            r_rsp_match <= w_match;
            r_rr_ptr    <= (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
        end else if (rsp_ready) begin
            r_slot <= SLOT_EMPTY;
        end
    end

    assign rsp_valid = (r_slot == SLOT_FULL);
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_match = r_rsp_match;

`ifdef DEC_MATCH_COUNT_EN
    logic [CNT_W-1:0] r_match_cnt;

    // Clear has priority over a same-cycle increment; count saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst || match_clr) begin
            r_match_cnt <= '0;
        end else if (w_accept && w_match && (r_match_cnt != '1)) begin
            r_match_cnt <= r_match_cnt + 1'b1;
        end
    end

    assign match_cnt = r_match_cnt;
`endif

endmodule

// File: tb/tb_decoder1035_arbiter.sv
// Directed, table-driven bench for decoder1035_arbiter (NREQ=4, CNT_W=2).
module tb_decoder1035_arbiter;
    localparam logic [15:0] W = 16'h040B;
    localparam logic [15:0] Z = 16'h0000;
    localparam logic [15:0] F = 16'hFFFF;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_match;
`ifdef DEC_MATCH_COUNT_EN
    logic        match_clr;
    logic [1:0]  match_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    decoder1035_arbiter #(.NREQ(4), .CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef DEC_MATCH_COUNT_EN
        .match_clr (match_clr),
        .match_cnt (match_cnt),
`endif
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_match (rsp_match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  rv;
        logic [15:0] w0, w1, w2, w3;
        logic        rr;
        logic [3:0]  rq;
        logic        vld;
        logic [1:0]  id;
        logic [15:0] data;
        logic        m;
    } vec_t;

    vec_t tv[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // Expected rsp_* are the registered state before this vector's clock edge.
        tv[0]  = '{1'b0, 4'b0001, W, Z, W, F, 1'b1, 4'b0001, 1'b0, 2'd0, Z, 1'b0};
        tv[1]  = '{1'b0, 4'b0000, W, Z, W, F, 1'b1, 4'b0000, 1'b1, 2'd0, W, 1'b1};
        tv[2]  = '{1'b1, 4'b0000, W, Z, W, F, 1'b1, 4'b0000, 1'b0, 2'd0, W, 1'b1};
        tv[3]  = '{1'b0, 4'b1111, W, Z, W, F, 1'b1, 4'b0001, 1'b0, 2'd0, Z, 1'b0};
        tv[4]  = '{1'b0, 4'b1111, W, Z, W, F, 1'b1, 4'b0010, 1'b1, 2'd0, W, 1'b1};
        tv[5]  = '{1'b0, 4'b1111, W, Z, W, F, 1'b1, 4'b0100, 1'b1, 2'd1, Z, 1'b0};
        tv[6]  = '{1'b0, 4'b1111, W, Z, W, F, 1'b1, 4'b1000, 1'b1, 2'd2, W, 1'b1};
        tv[7]  = '{1'b0, 4'b1111, W, Z, W, F, 1'b1, 4'b0001, 1'b1, 2'd3, F, 1'b0};
        tv[8]  = '{1'b0, 4'b0000, W, Z, W, F, 1'b0, 4'b0000, 1'b1, 2'd0, W, 1'b1};
        tv[9]  = '{1'b0, 4'b0110, W, Z, W, F, 1'b0, 4'b0000, 1'b1, 2'd0, W, 1'b1};
        tv[10] = '{1'b0, 4'b0110, W, Z, W, F, 1'b0, 4'b0000, 1'b1, 2'd0, W, 1'b1};
        tv[11] = '{1'b0, 4'b0110, W, Z, W, F, 1'b0, 4'b0000, 1'b1, 2'd0, W, 1'b1};
        tv[12] = '{1'b0, 4'b0110, W, Z, W, F, 1'b1, 4'b0010, 1'b1, 2'd0, W, 1'b1};
        tv[13] = '{1'b0, 4'b0000, W, Z, W, F, 1'b1, 4'b0000, 1'b1, 2'd1, Z, 1'b0};
        tv[14] = '{1'b0, 4'b0100, W, Z, 16'd1034, F, 1'b1, 4'b0100, 1'b0, 2'd1, Z, 1'b0};
        tv[15] = '{1'b0, 4'b0100, W, Z, 16'd1037, F, 1'b1, 4'b0100, 1'b1, 2'd2, 16'd1034, 1'b0};
        tv[16] = '{1'b0, 4'b0100, W, Z, 16'h840B, F, 1'b1, 4'b0100, 1'b1, 2'd2, 16'd1037, 1'b0};
        tv[17] = '{1'b0, 4'b0100, W, Z, W, F, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h840B, 1'b0};
        tv[18] = '{1'b0, 4'b0000, W, Z, W, F, 1'b0, 4'b0000, 1'b1, 2'd2, W, 1'b1};
        tv[19] = '{1'b1, 4'b1000, W, Z, W, F, 1'b0, 4'b0000, 1'b1, 2'd2, W, 1'b1};
        tv[20] = '{1'b0, 4'b1000, W, Z, W, F, 1'b0, 4'b1000, 1'b0, 2'd0, Z, 1'b0};
        tv[21] = '{1'b0, 4'b1000, W, Z, W, F, 1'b0, 4'b0000, 1'b1, 2'd3, F, 1'b0};
        tv[22] = '{1'b0, 4'b0000, W, Z, W, F, 1'b1, 4'b0000, 1'b1, 2'd3, F, 1'b0};
        tv[23] = '{1'b0, 4'b0011, W, Z, W, F, 1'b1, 4'b0001, 1'b0, 2'd3, F, 1'b0};

        rst       = 1'b1;
        req_valid = '0;
        req_data  = {F, W, Z, W};
        rsp_ready = 1'b0;
`ifdef DEC_MATCH_COUNT_EN
        match_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);

        for (int v = 0; v < 24; v++) begin
            @(negedge clk);
            rst       = tv[v].rst;
            req_valid = tv[v].rv;
            req_data  = {tv[v].w3, tv[v].w2, tv[v].w1, tv[v].w0};
            rsp_ready = tv[v].rr;
            #1;
            check($sformatf("v%0d req_ready", v), 32'(req_ready), 32'(tv[v].rq));
            check($sformatf("v%0d rsp_valid", v), 32'(rsp_valid), 32'(tv[v].vld));
            check($sformatf("v%0d rsp_id", v),    32'(rsp_id),    32'(tv[v].id));
            check($sformatf("v%0d rsp_data", v),  32'(rsp_data),  32'(tv[v].data));
            check($sformatf("v%0d rsp_match", v), 32'(rsp_match), 32'(tv[v].m));
        end

        // Requester 2 gives up while the slot is full; the pointer alone picks 3 next.
        @(negedge clk);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        #1;
        check("drop req_ready blocked", 32'(req_ready), 32'h0);
        check("drop rsp_id held", 32'(rsp_id), 32'd0);
        @(negedge clk);
        req_valid = 4'b1000;
        rsp_ready = 1'b1;
        #1;
        check("drop grant to 3", 32'(req_ready), 32'b1000);
        @(negedge clk);
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        #1;
        check("drop rsp_id", 32'(rsp_id), 32'd3);
        check("drop rsp_data", 32'(rsp_data), 32'(F));
        check("drop rsp_match", 32'(rsp_match), 32'd0);

`ifdef DEC_MATCH_COUNT_EN
        begin
            logic [1:0] exp_cnt[5];
            exp_cnt[0] = 2'd1;
            exp_cnt[1] = 2'd2;
            exp_cnt[2] = 2'd3;
            exp_cnt[3] = 2'd3;
            exp_cnt[4] = 2'd3;
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst       = 1'b0;
            req_valid = 4'b0001;
            req_data  = {F, W, Z, W};
            rsp_ready = 1'b1;
            #1;
            check("cnt after reset", 32'(match_cnt), 32'd0);
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                #1;
                check($sformatf("cnt match %0d", k + 1), 32'(match_cnt), 32'(exp_cnt[k]));
            end
            match_clr = 1'b1;
            @(negedge clk);
            #1;
            check("cnt clear wins", 32'(match_cnt), 32'd0);
            match_clr = 1'b0;
            req_valid = 4'b0000;
            @(negedge clk);
            #1;
            check("cnt idle", 32'(match_cnt), 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
